// File: rtl/rect_motion_ctl.sv
// Frame-rate position controller: bounces (or, with RECT_WRAP_EN, wraps) a rectangle
// inside the visible area, freezing it with a tint request for a number of frames on a hit.
module rect_motion_ctl #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned HEIGHT     = 64,
    parameter int unsigned MAX_X      = 800,
    parameter int unsigned MAX_Y      = 600,
    parameter int unsigned X_INIT     = 0,
    parameter int unsigned Y_INIT     = 0,
    parameter int unsigned SPEED      = 2,
    parameter int unsigned HIT_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        vblnk_in,
    input  logic        hit_in,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        collision_out,
    output logic        running,
    output logic [1:0]  state
);

    localparam int unsigned POS_W = 12;
    localparam int unsigned CMP_W = 13;
    localparam int unsigned CNT_W = 8;

    localparam logic [CMP_W-1:0] LIM_X = CMP_W'(MAX_X - WIDTH);
    localparam logic [CMP_W-1:0] LIM_Y = CMP_W'(MAX_Y - HEIGHT);
    localparam logic [CMP_W-1:0] SPD   = CMP_W'(SPEED);
    localparam logic [POS_W-1:0] XI    = POS_W'(X_INIT);
    localparam logic [POS_W-1:0] YI    = POS_W'(Y_INIT);
    localparam logic [CNT_W-1:0] CNT_I = CNT_W'(HIT_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FREEZE = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [POS_W-1:0]  x_q, x_d, y_q, y_d;
    logic              dir_x_q, dir_x_d, dir_y_q, dir_y_d;   // 1 = moving toward zero
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              coll_q, coll_d;
    logic              run_q, run_d;
    logic              vblnk_q;
    logic              tick;
    logic [POS_W:0]    step_x, step_y;

    // One-axis move; returns {new_dir, new_pos}, compares done 13 bits wide.
    function automatic logic [POS_W:0] step(input logic [POS_W-1:0] pos,
                                            input logic dir_neg,
                                            input logic [CMP_W-1:0] lim);
        logic [CMP_W-1:0] p, sum, dif;
        logic [POS_W:0]   r;
        p   = {1'b0, pos};
        sum = p + SPD;
        dif = p - SPD;
`ifdef RECT_WRAP_EN
        if (!dir_neg) r = (sum > lim) ? {1'b0, {POS_W{1'b0}}} : {1'b0, sum[POS_W-1:0]};
        else          r = (p < SPD)   ? {1'b1, lim[POS_W-1:0]} : {1'b1, dif[POS_W-1:0]};
`else
        if (!dir_neg) r = (sum >= lim) ? {1'b1, lim[POS_W-1:0]} : {1'b0, sum[POS_W-1:0]};
        else          r = (p < SPD)    ? {1'b0, {POS_W{1'b0}}} : {1'b1, dif[POS_W-1:0]};
`endif
        return r;
    endfunction

    assign tick   = vblnk_in & ~vblnk_q;
    assign step_x = step(x_q, dir_x_q, LIM_X);
    assign step_y = step(y_q, dir_y_q, LIM_Y);

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= XI;
            y_q     <= YI;
            dir_x_q <= 1'b0;
            dir_y_q <= 1'b0;
            cnt_q   <= '0;
            coll_q  <= 1'b0;
            run_q   <= 1'b0;
            vblnk_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            cnt_q   <= cnt_d;
            coll_q  <= coll_d;
            run_q   <= run_d;
            vblnk_q <= vblnk_in;
        end
    end

    // Next-state logic; stop overrides everything, including a same-cycle tick.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        cnt_d   = cnt_q;
        coll_d  = coll_q;

        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (tick) begin
                    if (hit_in) begin
                        state_d = FREEZE;
                        coll_d  = 1'b1;
                        cnt_d   = CNT_I;
                    end else begin
                        x_d     = step_x[POS_W-1:0];
                        dir_x_d = step_x[POS_W];
                        y_d     = step_y[POS_W-1:0];
                        dir_y_d = step_y[POS_W];
                    end
                end
            end
            FREEZE: begin
                if (tick) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = RUN;
                        coll_d  = 1'b0;
                        dir_x_d = ~dir_x_q;
                        dir_y_d = ~dir_y_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (stop) begin
            state_d = IDLE;
            x_d     = XI;
            y_d     = YI;
            dir_x_d = 1'b0;
            dir_y_d = 1'b0;
            cnt_d   = '0;
            coll_d  = 1'b0;
        end

        run_d = (state_d != IDLE);
    end

    assign x_pos         = x_q;
    assign y_pos         = y_q;
    assign collision_out = coll_q;
    assign running       = run_q;
    assign state         = state_q;

endmodule

// File: doc/rect_motion_ctl.md
Name: rect_motion_ctl

Overview:
- Frame-rate position controller for the rectangle sprite drawer.
- Generates x_pos/y_pos once per frame and bounces the rectangle inside the visible area.
- On a collision event it freezes the sprite and asserts the collision tint flag for a programmable number of frames, then reverses direction.
- Sits between the VGA timing chain (taps vblnk) and the rectangle drawer's x_pos/y_pos/collision inputs.

Parameters:
- WIDTH, 64, rectangle width in pixels.
- HEIGHT, 64, rectangle height in pixels.
- MAX_X, 800, visible horizontal pixels.
- MAX_Y, 600, visible vertical lines.
- X_INIT, 0, reset/restart x position.
- Y_INIT, 0, reset/restart y position.
- SPEED, 2, pixels moved per frame on each axis (1..63).
- HIT_FRAMES, 30, frames spent in FREEZE after a hit (1..255).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; begin motion from IDLE.
- stop  in  1  level; return to IDLE and restore init position.
- vblnk_in  in  1  vertical blank from timing chain.
- hit_in  in  1  external collision detect.
- x_pos  out  12  rectangle left edge, registered.
- y_pos  out  12  rectangle top edge, registered.
- collision_out  out  1  tint request to drawer, registered.
- running  out  1  high in RUN or FREEZE.
- state  out  2  00 IDLE, 01 RUN, 10 FREEZE.

Behaviour:
- Reset (async, rst_n=0): x_pos=X_INIT, y_pos=Y_INIT, dir_x=+, dir_y=+, state=IDLE, collision_out=0, running=0, freeze counter=0, vblnk_q=0.
- Frame tick: tick = vblnk_in & ~vblnk_q, where vblnk_q is vblnk_in registered each clk. All position, direction and counter updates occur only on tick edges, so the position never changes during active video. Latency: the update is visible at the clk edge at which vblnk_in is first sampled 1.
- IDLE:
  - Position held.
  - start=1 and stop=0 -> RUN on the next clk; no tick needed.
- RUN, on tick:
  - If hit_in=1: go to FREEZE, collision_out<=1, counter<=HIT_FRAMES-1, position held.
  - Otherwise, each axis moves independently:
    - +dir: if pos+SPEED >= MAX_X-WIDTH (MAX_Y-HEIGHT for y), then pos<=limit and dir<=-; else pos<=pos+SPEED.
    - -dir: if pos < SPEED, then pos<=0 and dir<=+; else pos<=pos-SPEED.
  - All compares are done in 13-bit unsigned, so no wrap.
- FREEZE, on tick:
  - If counter != 0: counter decrements; position held; collision_out stays 1.
  - If counter == 0: dir_x and dir_y both invert, collision_out<=0, state goes to RUN. The first move happens on the next tick.
  - hit_in is ignored in FREEZE.
- stop=1 in any state: on the next clk (tick not required), state<=IDLE, position<=init, dirs<=+, collision_out<=0. stop wins over start and over a simultaneous tick.
- start is ignored outside IDLE.
- Positions stay in 0..MAX_X-WIDTH and 0..MAX_Y-HEIGHT at all times.
- Reset mid-frame or mid-FREEZE returns everything to reset values immediately.

Optional Feature:
- Macro: RECT_WRAP_EN.
- Defined: edges wrap instead of bouncing; direction never changes at an edge.
  - +dir: pos+SPEED > MAX_X-WIDTH gives pos<=0.
  - -dir: pos < SPEED gives pos<=MAX_X-WIDTH.
  - Same rule on the y axis.
  - FREEZE exit still inverts both directions.
- Undefined: bounce behaviour as described in Behaviour.

Test Plan:
- Reset check: rst_n low, then high; toggle vblnk 3 frames with start=0 -> x_pos=0, y_pos=0, state=00, collision_out=0.
- Basic motion: start=1, then 3 vblnk rising edges -> x_pos=6, y_pos=6, state=01; no change between edges.
- Right-edge bounce: X_INIT=734; run 1 tick -> x_pos=736, dir_x=-; next tick -> x_pos=734.
- Hit handling: hit_in=1 at a RUN tick with HIT_FRAMES=3 -> collision_out=1 and position frozen for 4 ticks total; on the 4th tick collision_out=0 and directions invert; the next tick moves position by -2 on both axes.
- Stop priority: stop=1, start=1 and vblnk rising edge all in the same cycle while in FREEZE -> next clk state=00, x_pos=X_INIT, collision_out=0.
- RECT_WRAP_EN: x_pos=735, +dir, SPEED=2 -> next tick x_pos=0; x_pos=1, -dir -> next tick x_pos=736.
